// File: rtl/fc_mac_acc.sv
// FC neuron MAC: signed dot product per beat, accumulated over a multi-beat neuron on top of a bias,
// then requantised (arithmetic shift, optional ReLU, saturation) to a single output with a one-cycle pulse.
module fc_mac_acc #(
    parameter int DATA_NUM     = 20,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int SHIFT        = 7
) (
    input  logic                               clk,
    input  logic                               srstn,
    input  logic [DATA_NUM*DATA_WIDTH-1:0]     src_window,
    input  logic [DATA_NUM*WEIGHT_WIDTH-1:0]   weight_window,
    input  logic [BIAS_WIDTH-1:0]              bias,
    input  logic                               start,
    input  logic                               beat_valid,
    input  logic                               beat_last,
    input  logic                               relu_en,
    output logic                               busy,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   psum_q, psum_d;
    logic                          psum_vld_q, psum_vld_d;
    logic                          relu_q, relu_d;
    logic                          out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;

    logic signed [PROD_W-1:0]      prod [DATA_NUM];
    logic signed [ACC_WIDTH-1:0]   dot_sum;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]         requant_val;
    logic signed [ACC_WIDTH-1:0]   bias_ext;

    generate
        for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_mul
            assign prod[gi] = $signed(src_window[gi*DATA_WIDTH +: DATA_WIDTH])
                            * $signed(weight_window[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        end
    endgenerate

    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < DATA_NUM; i++) begin
            dot_sum = dot_sum + $signed({{(ACC_WIDTH-PROD_W){prod[i][PROD_W-1]}}, prod[i]});
        end
    end

    assign bias_ext = $signed({{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias});

    // Floor shift, then clamp negatives if ReLU was latched, then saturate to the output range
    always_comb begin
        shifted = acc_q >>> SHIFT;
        if (relu_q && shifted[ACC_WIDTH-1]) begin
            shifted = '0;
        end
        if (shifted > SAT_MAX) begin
            requant_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            requant_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            requant_val = shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            psum_q      <= '0;
            psum_vld_q  <= 1'b0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            psum_q      <= psum_d;
            psum_vld_q  <= psum_vld_d;
            relu_q      <= relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (beat_valid && beat_last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The last psum lands in acc during DRAIN, so DONE sees the final total
    always_comb begin
        psum_d      = psum_q;
        psum_vld_d  = 1'b0;
        acc_d       = acc_q;
        relu_d      = relu_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (state_q == ACC && beat_valid) begin
            psum_d     = dot_sum;
            psum_vld_d = 1'b1;
        end
        if (state_q == IDLE && start) begin
            acc_d  = bias_ext;
            relu_d = relu_en;
        end else if (psum_vld_q) begin
            acc_d = acc_q + psum_q;
        end
        if (state_q == DONE) begin
            out_valid_d = 1'b1;
            out_data_d  = requant_val;
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/fc_mac_acc.md
Name: fc_mac_acc

Overview:
Downstream consumer of the FC data register's registered `src_window`. It forms a signed dot product of `DATA_NUM` activations against a matching weight window each beat. Partial sums accumulate over a multi-beat neuron on top of a bias. The total is then requantised (arithmetic shift, optional ReLU, saturation) to one `DATA_WIDTH` output neuron with a one-cycle `out_valid` pulse, which feeds the FC output SRAM writer.

Parameters:
- DATA_NUM, 20, activation/weight elements per beat
- DATA_WIDTH, 8, signed activation width; also output width
- WEIGHT_WIDTH, 8, signed weight width
- BIAS_WIDTH, 16, signed bias width
- ACC_WIDTH, 32, signed accumulator width
- SHIFT, 7, requantisation right-shift amount

Ports:
- clk  in  1  clock
- srstn  in  1  synchronous active-low reset
- src_window  in  DATA_NUM*DATA_WIDTH  activation window, registered by the upstream data register
- weight_window  in  DATA_NUM*WEIGHT_WIDTH  weight window, aligned to src_window in the same cycle
- bias  in  BIAS_WIDTH  signed neuron bias, sampled on start
- start  in  1  begin a new neuron
- beat_valid  in  1  src_window/weight_window valid this cycle
- beat_last  in  1  qualifies beat_valid as the final beat of the neuron
- relu_en  in  1  apply ReLU, sampled on start
- busy  out  1  neuron in progress
- out_valid  out  1  one-cycle pulse; out_data valid
- out_data  out  DATA_WIDTH  signed requantised neuron output

Behaviour:
- Reset and clock: srstn is synchronous and active-low; clock is clk. On reset: state=IDLE, busy=0, out_valid=0, out_data=0, acc=0, psum=0, psum_vld=0, latched relu=0. Reset mid-operation abandons the neuron; nothing is output.
- Element pairing: element i is src_window[i*DATA_WIDTH +: DATA_WIDTH] paired with weight_window[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]. Both operands are signed two's complement.
- Stage 1 (registered): when state=ACC and beat_valid=1:
  - psum <= sum of the DATA_NUM signed products, computed at full precision and sign-extended to ACC_WIDTH.
  - psum_vld <= 1; otherwise psum_vld <= 0.
- Stage 2: when psum_vld=1, acc <= acc + psum. This is a two's-complement wrap at ACC_WIDTH; there is no saturation inside the accumulator.
- FSM states IDLE, ACC, DRAIN, DONE:
  - IDLE: busy=0. On start=1: acc <= sign-extended bias; latch relu_en; go to ACC. beat_valid in IDLE is ignored, including when it coincides with start.
  - ACC: busy=1. Beats are accepted on any cycle with beat_valid=1; gap cycles are allowed. On beat_valid=1 with beat_last=1, go to DRAIN. beat_last without beat_valid is ignored.
  - DRAIN: the final psum is added to acc; go to DONE. Any beat_valid here is ignored.
  - DONE: out_data <= requant(acc); out_valid <= 1 for the next cycle only; go to IDLE. busy deasserts in the same cycle out_valid is high.
- start while busy=1 is ignored.
- Latency: out_valid is high exactly 3 cycles after the cycle in which the beat with beat_last=1 is accepted. A new start is accepted in the out_valid cycle, giving back-to-back neurons with a 1-cycle bubble.
- requant(x):
  - y = x >>> SHIFT (arithmetic shift, floor; no rounding).
  - If relu latched and y<0, then y=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- out_data holds its value until the next DONE; it is not cleared after the out_valid pulse.

Test Plan:
- Basic dot product: 1 beat, all src=8, w=8, bias=0, relu=0 -> acc=1280, out_data=10 (0x0A), out_valid exactly 3 cycles after the beat, single-cycle pulse.
- ReLU: src=8, w=-8 (0xF8), bias=0. With relu=0 -> out_data=0xF6 (-10). With relu=1 -> out_data=0x00.
- Floor and bias: src=1, w=1, bias=-21 -> acc=-1, out_data=0xFF. With bias=0 -> 20>>>7, out_data=0x00. With src=8, w=8, bias=-1280 -> out_data=0x00.
- Saturation and multi-beat: 4 beats of src=127, w=127 with idle gaps between beats -> acc=1290320, shifted value 10080, out_data=0x7F. Repeat with w=-128 -> out_data=0x80.
- Protocol: start and beat_valid pulsed while busy or in IDLE are ignored (result unchanged). A new start in the out_valid cycle is accepted and its neuron produces the correct output.
- Reset mid-op: assert srstn=0 for 1 cycle after 2 of 4 beats -> no out_valid, busy=0, out_data=0. A following neuron computes correctly from fresh bias.
